ov7670_config_ctrl: RTL and testbench

OV7670_CONFIG_CTRL -- requirements
Module: ov7670_config_ctrl

---
 rtl/ov7670_cfg_pkg.sv | 24 ++
 rtl/ov7670_cfg_delay_timer.sv | 27 ++
 rtl/ov7670_config_ctrl.sv | 152 +++++++++++++++
 tb/tb_ov7670_config_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_cfg_pkg.sv
// Shared types and constants for the OV7670 register-configuration sequencer.
package ov7670_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    SEND,
    WAIT_ACK,
    DELAY,
    FINISH
  } state_t;

  localparam logic [15:0] ROM_END    = 16'hFFFF;
  localparam logic [15:0] ROM_DELAY  = 16'hFFF0;
  localparam int          ROM_ADDR_W = 5;
  localparam logic [ROM_ADDR_W-1:0] ROM_LAST = 5'd31;

  // Bits needed to hold the values 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ov7670_cfg_delay_timer.sv
// Down-counter for ROM delay markers: load N-1, expire reads high on the cycle the count is 0.
module ov7670_cfg_delay_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/ov7670_config_ctrl.sv
// Walks a 32-entry register ROM and issues SCCB writes, honouring end and delay markers.
// Optional NACK retry with a sticky cfg_err is built only when OV7670_CFG_RETRY_EN is defined.
module ov7670_config_ctrl
  import ov7670_cfg_pkg::*;
#(
  parameter int          CLK_FREQ_HZ = 25_000_000,
  parameter int          DELAY_MS    = 10,
  parameter logic [7:0]  SCCB_ID     = 8'h42,
  parameter int          MAX_RETRY   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [15:0]           rom_data,
  output logic                  sccb_req,
  output logic [7:0]            sccb_id,
  output logic [7:0]            sccb_reg,
  output logic [7:0]            sccb_val,
  input  logic                  sccb_ready,
  input  logic                  sccb_done,
  input  logic                  sccb_err,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int DELAY_CYCLES = CLK_FREQ_HZ / 1000 * DELAY_MS;
  localparam int CNT_W        = cnt_width(DELAY_CYCLES);
  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY_CYCLES - 1);

  state_t state, state_nxt;
  logic   start_accept;
  logic   advance;
  logic   load_delay;
  logic   delay_expire;
  logic   retry;

  // A start landing on the same cycle as a completion pulse is treated as spurious.
  assign start_accept = start && !sccb_done && (state == IDLE || state == FINISH);
  assign sccb_id      = SCCB_ID;

  ov7670_cfg_delay_timer #(.CNT_W(CNT_W)) u_delay_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_delay),
    .load_val (DELAY_LOAD),
    .expire   (delay_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every variable written here gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    advance    = 1'b0;
    load_delay = 1'b0;
    case (state)
      IDLE, FINISH: if (start_accept) state_nxt = FETCH;
      FETCH:        state_nxt = DECODE;
      DECODE: begin
        if (rom_data == ROM_END) begin
          state_nxt = FINISH;
        end else if (rom_data == ROM_DELAY) begin
          load_delay = 1'b1;
          state_nxt  = DELAY;
        end else begin
          state_nxt = SEND;
        end
      end
      SEND:     if (sccb_ready) state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (sccb_done) begin
          if (retry) state_nxt = SEND;
          else       advance   = 1'b1;
        end
      end
      DELAY:    if (delay_expire) advance = 1'b1;
      default:  state_nxt = IDLE;
    endcase
    if (advance) state_nxt = (rom_addr == ROM_LAST) ? FINISH : FETCH;
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    sccb_req = 1'b0;
    case (state)
      FETCH, DECODE, WAIT_ACK, DELAY: busy = 1'b1;
      SEND: begin
        busy     = 1'b1;
        sccb_req = 1'b1;
      end
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  // rom_addr saturates at the last entry; the run finishes there instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
      sccb_reg <= '0;
      sccb_val <= '0;
    end else begin
      if (start_accept) begin
        rom_addr <= '0;
      end else if (advance && rom_addr != ROM_LAST) begin
        rom_addr <= rom_addr + 1'b1;
      end
      if (state == DECODE && rom_data != ROM_END && rom_data != ROM_DELAY) begin
        sccb_reg <= rom_data[15:8];
        sccb_val <= rom_data[7:0];
      end
    end
  end

`ifdef OV7670_CFG_RETRY_EN
  localparam int RETRY_W = cnt_width(MAX_RETRY + 1);

  logic [RETRY_W-1:0] retry_cnt;
  logic               nack;
  logic               cfg_err_q;

  assign nack  = (state == WAIT_ACK) && sccb_done && sccb_err;
  assign retry = nack && (retry_cnt < RETRY_W'(MAX_RETRY));

  always_ff @(posedge clk) begin
    if (reset) begin
      retry_cnt <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      if (advance)    retry_cnt <= '0;
      else if (retry) retry_cnt <= retry_cnt + 1'b1;
      if (start_accept)        cfg_err_q <= 1'b0;
      else if (nack && !retry) cfg_err_q <= 1'b1;
    end
  end

  assign cfg_err = cfg_err_q;
`else
  logic unused_sccb_err;

  assign retry           = 1'b0;
  assign cfg_err         = 1'b0;
  assign unused_sccb_err = sccb_err;
`endif

endmodule

// File: tb/tb_ov7670_config_ctrl.sv
// Directed bench for ov7670_config_ctrl: 5-cycle delay build, 1-cycle ROM model, SCCB responder.
module tb_ov7670_config_ctrl;

  localparam int CLK_FREQ_HZ = 1000;
  localparam int DELAY_MS    = 5;
  localparam int MAX_RETRY   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sccb_req;
  logic [7:0]  sccb_id;
  logic [7:0]  sccb_reg;
  logic [7:0]  sccb_val;
  logic        sccb_ready;
  logic        sccb_done;
  logic        sccb_err = 1'b0;
  logic        busy;
  logic        done;
  logic        cfg_err;

  logic        resp_done   = 1'b0;
  logic        manual_done = 1'b0;
  logic        err_mode    = 1'b0;

  logic [15:0] rom [32];
  logic [7:0]  wr_reg [$];
  logic [7:0]  wr_val [$];
  int          wr_cyc [$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  ov7670_config_ctrl #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .DELAY_MS    (DELAY_MS),
    .SCCB_ID     (8'h42),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .sccb_req   (sccb_req),
    .sccb_id    (sccb_id),
    .sccb_reg   (sccb_reg),
    .sccb_val   (sccb_val),
    .sccb_ready (sccb_ready),
    .sccb_done  (sccb_done),
    .sccb_err   (sccb_err),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  assign sccb_done = resp_done | manual_done;

  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(posedge clk) cyc <= cyc + 1;

  // SCCB master model: logs each accepted write, answers with done three cycles later.
  initial begin : responder
    forever begin
      @(negedge clk);
      if (sccb_req && sccb_ready) begin
        wr_reg.push_back(sccb_reg);
        wr_val.push_back(sccb_val);
        wr_cyc.push_back(cyc);
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 resp_done = 1'b1;
        sccb_err = err_mode;
        @(posedge clk);
        #1 resp_done = 1'b0;
        sccb_err = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n = 0;
    while (sccb_req !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, sccb_req}, 32'd1);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = 16'hFFFF;
  endtask

  task automatic clear_log();
    wr_reg.delete();
    wr_val.delete();
    wr_cyc.delete();
  endtask

  initial begin : stimulus
    reset      = 1'b1;
    start      = 1'b0;
    sccb_ready = 1'b1;
    clear_rom();
    tick(3);

    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_req",      32'(sccb_req), 32'd0);
    check("rst_reg",      32'(sccb_reg), 32'd0);
    check("rst_val",      32'(sccb_val), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_cfg_err",  32'(cfg_err),  32'd0);
    check("rst_id",       32'(sccb_id),  32'h42);
    reset = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Basic sequence with one delay marker between two writes.
    rom[0] = 16'h1280;
    rom[1] = 16'hFFF0;
    rom[2] = 16'h3A04;
    rom[3] = 16'hFFFF;
    clear_log();
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_done_low", 32'(done), 32'd0);
    wait_done("t1_done", 200);
    check("t1_writes", 32'(wr_reg.size()), 32'd2);
    check("t1_reg0", 32'(wr_reg[0]), 32'h12);
    check("t1_val0", 32'(wr_val[0]), 32'h80);
    check("t1_reg1", 32'(wr_reg[1]), 32'h3A);
    check("t1_val1", 32'(wr_val[1]), 32'h04);
    // accept k, done k+3, FETCH/DECODE, 5 delay cycles, FETCH/DECODE/SEND, accept k+13
    check("t1_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd13);
    check("t1_rom_addr", 32'(rom_addr), 32'd3);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_cfg_err", 32'(cfg_err), 32'd0);

    // Backpressure: request must hold steady until ready rises.
    clear_rom();
    rom[0] = 16'h1101;
    clear_log();
    sccb_ready = 1'b0;
    pulse_start();
    wait_req("t2_req_seen", 20);
    for (int i = 0; i < 10; i++) begin
      check("t2_req_hold", 32'(sccb_req), 32'd1);
      check("t2_reg_hold", 32'(sccb_reg), 32'h11);
      check("t2_val_hold", 32'(sccb_val), 32'h01);
      tick();
    end
    check("t2_no_accept", 32'(wr_reg.size()), 32'd0);
    sccb_ready = 1'b1;
    wait_done("t2_done", 100);
    check("t2_writes", 32'(wr_reg.size()), 32'd1);
    check("t2_reg", 32'(wr_reg[0]), 32'h11);

    // No wrap: 32 ordinary entries, finish at address 31.
    for (int i = 0; i < 32; i++) rom[i] = {8'(i + 1), 8'(i)};
    clear_log();
    pulse_start();
    wait_done("t3_done", 1000);
    check("t3_writes", 32'(wr_reg.size()), 32'd32);
    check("t3_rom_addr", 32'(rom_addr), 32'd31);
    check("t3_first_reg", 32'(wr_reg[0]), 32'h01);
    check("t3_last_reg", 32'(wr_reg[31]), 32'h20);
    check("t3_last_val", 32'(wr_val[31]), 32'h1F);
    tick(10);
    check("t3_no_extra", 32'(wr_reg.size()), 32'd32);

    // Reset while waiting for the acknowledge.
    clear_rom();
    rom[0] = 16'h1280;
    clear_log();
    pulse_start();
    wait_req("t4_req_seen", 20);
    tick();
    check("t4_req_dropped", 32'(sccb_req), 32'd0);
    check("t4_busy_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check("t4_rom_addr", 32'(rom_addr), 32'd0);
    check("t4_req",      32'(sccb_req), 32'd0);
    check("t4_reg",      32'(sccb_reg), 32'd0);
    check("t4_val",      32'(sccb_val), 32'd0);
    check("t4_busy",     32'(busy),     32'd0);
    check("t4_done",     32'(done),     32'd0);
    check("t4_cfg_err",  32'(cfg_err),  32'd0);
    check("t4_id",       32'(sccb_id),  32'h42);
    reset = 1'b0;
    tick(6);
    check("t4_idle_busy", 32'(busy), 32'd0);
    check("t4_idle_done", 32'(done), 32'd0);
    clear_log();
    pulse_start();
    check("t4_restart_addr", 32'(rom_addr), 32'd0);
    wait_done("t4_rerun_done", 100);
    check("t4_rerun_writes", 32'(wr_reg.size()), 32'd1);
    check("t4_rerun_reg", 32'(wr_reg[0]), 32'h12);
    check("t4_rerun_addr", 32'(rom_addr), 32'd1);

    // Start filtering: ignored while busy and when it coincides with sccb_done.
    clear_rom();
    rom[0] = 16'h0102;
    rom[1] = 16'h0304;
    clear_log();
    pulse_start();
    wait_req("t5_req_seen", 20);
    tick();
    pulse_start();
    check("t5_busy_kept", 32'(busy), 32'd1);
    wait_done("t5_done", 100);
    check("t5_writes", 32'(wr_reg.size()), 32'd2);
    check("t5_rom_addr", 32'(rom_addr), 32'd2);
    manual_done = 1'b1;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    manual_done = 1'b0;
    check("t5_start_on_done_done", 32'(done), 32'd1);
    check("t5_start_on_done_busy", 32'(busy), 32'd0);
    pulse_start();
    check("t5_restart_done_low", 32'(done), 32'd0);
    check("t5_restart_busy", 32'(busy), 32'd1);
    wait_done("t5_done2", 100);
    check("t5_writes2", 32'(wr_reg.size()), 32'd4);

    // NACK on every write.
    clear_rom();
    rom[0] = 16'h1280;
    rom[1] = 16'h3A04;
    clear_log();
    err_mode = 1'b1;
    pulse_start();
    wait_done("t6_done", 400);
`ifdef OV7670_CFG_RETRY_EN
    check("t6_writes", 32'(wr_reg.size()), 32'd8);
    check("t6_reg3", 32'(wr_reg[3]), 32'h12);
    check("t6_val3", 32'(wr_val[3]), 32'h80);
    check("t6_reg4", 32'(wr_reg[4]), 32'h3A);
    check("t6_cfg_err", 32'(cfg_err), 32'd1);
`else
    check("t6_writes", 32'(wr_reg.size()), 32'd2);
    check("t6_reg1", 32'(wr_reg[1]), 32'h3A);
    check("t6_cfg_err", 32'(cfg_err), 32'd0);
`endif
    check("t6_rom_addr", 32'(rom_addr), 32'd2);
    err_mode = 1'b0;
    pulse_start();
    check("t6_cfg_err_cleared", 32'(cfg_err), 32'd0);
    wait_done("t6_done2", 100);
    check("t6_cfg_err_clean", 32'(cfg_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
